line_clear_fsm: RTL and testbench
=================================

LINE_CLEAR_FSM -- requirements
Module: line_clear_fsm

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of board rows; address 0 = top row, ROWS-1 = bottom row.
REQ-002 SHALL have parameter COLS, default 12, bits per row; matches the board row-register width.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to scan and compact the board (piece landed).
REQ-006 SHALL have port rd_addr, output, 4, board read address.
REQ-007 SHALL have port rd_data, input, COLS, row contents at rd_addr, combinational read, valid in the same cycle.
REQ-008 SHALL have port wr_en, output, 1, board write strobe.
REQ-009 SHALL have port wr_addr, output, 4, board write address.
REQ-010 SHALL have port wr_data, output, COLS, row value to write.
REQ-011 SHALL have port busy, output, 1, high in SCAN and FILL.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at completion.
REQ-013 SHALL have port lines_cleared, output, 5, full-row count of the last completed operation.
REQ-014 SHALL have port score, output, 16, accumulated score.

Function
REQ-015 SHALL implement states IDLE, SCAN, FILL and DONE.
REQ-016 SHALL, in IDLE, move to SCAN on the cycle after start=1 is sampled; at that edge rd_ptr=wr_ptr=ROWS-1 and the internal count clears to 0.
REQ-017 SHALL ignore start in all states other than IDLE, with no queuing.
REQ-018 SHALL, in SCAN, drive rd_addr=rd_ptr and process exactly one row per cycle.
REQ-019 SHALL treat a row as full when rd_data equals all-ones (12'hFFF); a full row is not written, count increments, and rd_ptr decrements.
REQ-020 SHALL, for a non-full row, assert wr_en with wr_addr=wr_ptr and wr_data=rd_data, then decrement both pointers; the write occurs even when wr_ptr equals rd_ptr.
REQ-021 SHALL leave SCAN after the row at rd_ptr=0 is processed, so SCAN lasts exactly ROWS cycles; the next state is FILL if count>0, otherwise DONE.
REQ-022 SHALL, in FILL, write zero rows (wr_en=1, wr_data=0) at wr_ptr, decrementing once per cycle, for exactly count cycles, ending with wr_addr=0, then go to DONE.
REQ-023 SHALL, in DONE, pulse done for exactly one cycle, latch lines_cleared=count, update score, then return to IDLE.
REQ-024 SHALL add to score 0/40/100/300/1200 for count 0/1/2/3/>=4 respectively.
REQ-025 SHALL saturate score at 16'hFFFF and never wrap.
REQ-026 SHALL take ROWS+count+1 cycles from the first busy cycle to the done cycle, inclusive.
REQ-027 SHALL hold wr_en=0 in IDLE and DONE, and SHALL hold rd_addr at 0 outside SCAN.
REQ-028 SHALL issue exactly ROWS writes per operation in total across SCAN and FILL, and no address SHALL be written twice.

Reset
REQ-029 SHALL, when reset=1, go to IDLE on the next edge with busy=0, done=0, wr_en=0, lines_cleared=0, score=0, and pointers at ROWS-1.
REQ-030 SHALL, when reset is asserted during SCAN or FILL, abort the operation with no further writes from the following cycle and no done pulse; partially written board contents are not restored.
REQ-031 SHALL give reset priority over a simultaneous start.

Verification
REQ-032 SHALL verify: empty board, start -> 16 writes of 0 at the same addresses, no FILL, done at busy cycle 17, lines_cleared=0, score=0.
REQ-033 SHALL verify: row 15=FFF, row 14=0x555, others 0 -> row 15 becomes 0x555, row 0 becomes 0, lines_cleared=1, score=40, done at busy cycle 18.
REQ-034 SHALL verify: rows 12-15=FFF and row 11=0xAAA -> row 15=0xAAA, rows 0-3=0, lines_cleared=4, score=1200, 4 FILL cycles.
REQ-035 SHALL verify: rows 13 and 15=FFF, row 14=0x001 -> row 15=0x001, rows 0-1=0, score +100; start pulsed during busy is ignored.
REQ-036 SHALL verify: score preset near saturation via repeated 4-line clears -> score holds at 16'hFFFF.
REQ-037 SHALL verify: reset asserted in the 5th SCAN cycle -> wr_en=0 next cycle, no done, score=0, and a subsequent start runs normally.

Source files
------------

// File: rtl/line_clear_fsm.sv
// Line-clear engine: scans the board bottom-up, compacts non-full rows
// downward, zero-fills the vacated top rows and updates the score.
module line_clear_fsm #(
    parameter int ROWS = 16,
    parameter int COLS = 12
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            start,
    output logic [3:0]      rd_addr,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [3:0]      wr_addr,
    output logic [COLS-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [4:0]      lines_cleared,
    output logic [15:0]     score
);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ROWS - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  rd_ptr;
    logic [3:0]  wr_ptr;
    logic [4:0]  count;
    logic        full;
    logic [15:0] bonus;
    logic [16:0] score_sum;
    logic [15:0] score_nx;

    assign full = (rd_data == '1);

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: begin
                // count has not yet absorbed the row being read
                if (rd_ptr == 4'd0)
                    state_nx = (count != 5'd0 || full) ? FILL : DONE;
            end
            FILL: if (wr_ptr == 4'd0) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_addr = 4'd0;
        wr_en   = 1'b0;
        wr_addr = wr_ptr;
        wr_data = '0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: ;
            SCAN: begin
                busy    = 1'b1;
                rd_addr = rd_ptr;
                wr_en   = ~full;
                wr_data = rd_data;
            end
            FILL: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            DONE: done = 1'b1;
        endcase
    end

    always_comb begin
        case (count)
            5'd0:    bonus = 16'd0;
            5'd1:    bonus = 16'd40;
            5'd2:    bonus = 16'd100;
            5'd3:    bonus = 16'd300;
            default: bonus = 16'd1200;
        endcase
        score_sum = {1'b0, score} + {1'b0, bonus};
        score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            rd_ptr        <= LAST;
            wr_ptr        <= LAST;
            count         <= 5'd0;
            lines_cleared <= 5'd0;
            score         <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr <= LAST;
                        wr_ptr <= LAST;
                        count  <= 5'd0;
                    end
                end
                SCAN: begin
                    rd_ptr <= rd_ptr - 4'd1;
                    if (full) count  <= count + 5'd1;
                    else      wr_ptr <= wr_ptr - 4'd1;
                end
                FILL: wr_ptr <= wr_ptr - 4'd1;
                DONE: begin
                    lines_cleared <= count;
                    score         <= score_nx;
                    rd_ptr        <= LAST;
                    wr_ptr        <= LAST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_fsm.sv
// Bench for line_clear_fsm: board memory model, vector table and
// scoreboard of expected results checked at each done pulse.
module tb_line_clear_fsm;

    localparam int ROWS = 16;
    localparam int COLS = 12;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct {
        board_t b;
        int     lines;
        int     add;
        bit     pulse;
    } vec_t;

    typedef struct {
        board_t      b;
        int          lines;
        logic [15:0] score;
        int          cycles;
    } exp_t;

    logic            Clk;
    logic            reset;
    logic            start;
    logic [3:0]      rd_addr;
    logic [COLS-1:0] rd_data;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [COLS-1:0] wr_data;
    logic            busy;
    logic            done;
    logic [4:0]      lines_cleared;
    logic [15:0]     score;

    board_t          board;
    board_t          load_val;
    logic            load;
    logic            clr;
    int              wr_cnt;
    logic [ROWS-1:0] written;
    logic            dup;

    exp_t        sb[$];
    logic [15:0] exp_score;
    int          checks;
    int          errors;

    line_clear_fsm #(.ROWS(ROWS), .COLS(COLS)) dut (
        .Clk(Clk),
        .reset(reset),
        .start(start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .lines_cleared(lines_cleared),
        .score(score)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign rd_data = board[rd_addr];

    // Board memory plus write bookkeeping for the current operation
    always @(posedge Clk) begin
        if (load)       board <= load_val;
        else if (wr_en) board[wr_addr] <= wr_data;
        if (clr) begin
            wr_cnt  <= 0;
            written <= '0;
            dup     <= 1'b0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (written[wr_addr]) dup <= 1'b1;
            written[wr_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] s,
                                            input int a);
        int t;
        t = int'(s) + a;
        if (t > 65535) return 16'hFFFF;
        return 16'(t);
    endfunction

    // Reference: drop full rows, pack the rest to the bottom, zeros on top
    function automatic board_t compact(input board_t b);
        board_t o;
        int     w;
        o = '0;
        w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (b[r] != 12'hFFF) begin
                o[w] = b[r];
                w--;
            end
        end
        return o;
    endfunction

    task automatic load_board(input board_t b);
        @(negedge Clk);
        load     = 1'b1;
        load_val = b;
        clr      = 1'b1;
        @(negedge Clk);
        load = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic run_op(input board_t b, input int lines, input int add,
                          input bit pulse);
        exp_t e;
        int   cyc;
        bit   seen;
        load_board(b);
        start = 1'b1;
        e.b       = compact(b);
        e.lines   = lines;
        e.cycles  = ROWS + lines + 1;
        exp_score = sat_add(exp_score, add);
        e.score   = exp_score;
        sb.push_back(e);
        @(negedge Clk);
        start = 1'b0;
        chk("first_rd_addr", rd_addr, ROWS - 1);
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 100) begin
            if (done) begin
                seen = 1;
            end else begin
                start = (pulse && (cyc == 3 || cyc == 18));
                @(negedge Clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        e = sb.pop_front();
        if (seen) begin
            chk("done_cycle", cyc, e.cycles);
            chk("done_wr_en", wr_en, 0);
            chk("done_rd_addr", rd_addr, 0);
            @(negedge Clk);
            chk("done_pulse_len", done, 0);
            chk("idle_busy", busy, 0);
            chk("lines_cleared", lines_cleared, e.lines);
            chk("score", score, e.score);
            chk("write_count", wr_cnt, ROWS);
            chk("no_dup_write", dup, 0);
            chk("board", board, e.b);
            @(negedge Clk);
            chk("no_restart", busy, 0);
        end
    endtask

    vec_t tv[6];
    int   dcnt;

    initial begin
        checks    = 0;
        errors    = 0;
        exp_score = 16'd0;
        reset     = 1'b1;
        start     = 1'b0;
        load      = 1'b1;
        load_val  = '0;
        clr       = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_score", score, 0);
        chk("rst_rd_addr", rd_addr, 0);
        start = 1'b1;
        @(negedge Clk);
        chk("rst_over_start", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        clr   = 1'b0;

        foreach (tv[i]) begin
            tv[i].b     = '0;
            tv[i].pulse = 0;
        end
        tv[0].lines = 0;  tv[0].add = 0;
        tv[1].b[15] = 12'hFFF;
        tv[1].b[14] = 12'h555;
        tv[1].lines = 1;  tv[1].add = 40;
        for (int r = 12; r < 16; r++) tv[2].b[r] = 12'hFFF;
        tv[2].b[11] = 12'hAAA;
        tv[2].lines = 4;  tv[2].add = 1200;
        tv[3].b[15] = 12'hFFF;
        tv[3].b[13] = 12'hFFF;
        tv[3].b[14] = 12'h001;
        tv[3].lines = 2;  tv[3].add = 100; tv[3].pulse = 1;
        tv[4].b[0]  = 12'hFFF;
        tv[4].b[7]  = 12'hFFF;
        tv[4].b[3]  = 12'h123;
        tv[4].b[10] = 12'h800;
        tv[4].lines = 2;  tv[4].add = 100;
        for (int r = 0; r < 16; r++) tv[5].b[r] = 12'hFFF;
        tv[5].lines = 16; tv[5].add = 1200;

        for (int i = 0; i < 6; i++)
            run_op(tv[i].b, tv[i].lines, tv[i].add, tv[i].pulse);

        for (int i = 0; i < 54; i++)
            run_op(tv[2].b, 4, 1200, 0);
        chk("score_saturated", score, 16'hFFFF);

        // Abort in the 5th scan cycle
        load_board(tv[2].b);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("abort_rd_addr", rd_addr, 11);
        chk("abort_wr_en_pre", wr_en, 1);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        exp_score = 16'd0;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_score", score, 0);
        chk("abort_lines", lines_cleared, 0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || wr_en) dcnt++;
            @(negedge Clk);
        end
        chk("abort_quiet", dcnt, 0);
        chk("abort_partial_row15", board[15], 12'hAAA);
        run_op(board, 3, 300, 0);
        chk("recover_row14", board[14], 12'hAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
